dmw_store_buf: RTL
==================

# dmw_store_buf

Store-side counterpart of the load extender: accepts SB/SH/SW requests from the MEM stage, encodes each into a word-aligned address, a 4-bit byte-enable and lane-replicated write data, and holds them in a small FIFO store buffer. It drains the buffer to data memory through a valid/ack handshake. It also flags loads that hit a word with a pending store, so the hazard unit can stall them.

## Interface
- DEPTH, 2, number of store-buffer entries; power of two, at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- st_valid  in  1  MEM stage presents a store request.
- st_ready  out  1  buffer can accept; equals not-full.
- st_op  in  6  instr[31:26]; only `OP_SB`, `OP_SH` and `OP_SW` are acted on.
- st_addr  in  32  byte address (alu_result).
- st_data  in  32  rt register value.
- st_misalign  out  1  one-cycle pulse when a misaligned store is rejected.
- dm_we  out  1  head entry valid toward data memory.
- dm_addr  out  32  word address of head entry; bits [1:0] always 00.
- dm_be  out  4  byte enables of head entry; bit i covers dm_wd[8i+7:8i].
- dm_wd  out  32  lane-replicated write data of head entry.
- dm_ack  in  1  memory has written the head entry this cycle.
- ld_addr  in  32  byte address of the load currently in MEM.
- ld_hit  out  1  ld_addr[31:2] matches any valid buffered entry.
- empty  out  1  buffer holds no entries.

## Operation
- A request is accepted when st_valid && st_ready && st_op is a store op. If st_valid is high with a non-store op, nothing is written and no pulse is raised.
- Encoding by st_op and st_addr[1:0]:
  - SB: be = 4'b0001 << addr[1:0]; wd = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{data[15:0]}}.
  - SW: be = 4'b1111; wd = data.
  - Entry address is {addr[31:2], 2'b00}.
- The FIFO uses write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
- Drain:
  - The head entry drives dm_we=1, and dm_addr/dm_be/dm_wd stay stable until dm_ack.
  - dm_ack while dm_we=1 pops the head on that edge.
  - dm_ack while dm_we=0 is ignored.
  - When empty, dm_addr, dm_be and dm_wd are driven to 0.
- Push and pop in the same cycle leave the count unchanged and both pointers advance. When full, st_ready=0 even if dm_ack is high, so there is no combinational ack-to-ready path.
- ld_hit is combinational over the stored entries only; a store being accepted in the same cycle does not count.
- Reset mid-drain discards all entries with no completion; memory contents are left unspecified.

## Timing
- Reset values:
  - st_ready=1, empty=1, ld_hit follows the now-empty buffer (0).
  - dm_we=0, dm_addr=0, dm_be=0, dm_wd=0.
  - st_misalign=0.
- Latency: a store accepted at edge N into an empty buffer appears on dm_* in cycle N+1. Back-to-back entries are presented with no bubble after an ack.
- Throughput is one store per cycle while memory acks every cycle.
- st_misalign is registered: it is high for the single cycle after the rejected request edge.

## Configuration
- DMW_ALIGN_CHK_EN defined:
  - These requests are rejected with no entry written: SH with addr[0]=1, and SW with addr[1:0]≠00.
  - A rejected request still counts as taken (no stall), and st_misalign pulses.
- DMW_ALIGN_CHK_EN undefined:
  - st_misalign is tied to 0.
  - SH ignores addr[0] and SW ignores addr[1:0]; the request is encoded per the table above.

## Structure
- `OP_SB`, `OP_SH` and `OP_SW` opcodes live in the shared instr_def.v defines, alongside the load opcodes.
- The combinational encoder (op, addr[1:0], data → be, wd, misalign) is a sub-module, dmw_ext, the write-side mirror of the load extender.
- FIFO storage and pointers stay in dmw_store_buf.

## Test plan
- SB, addr=0x1003, data=0x000000A5, dm_ack held 1 → next cycle dm_we=1, dm_addr=0x1000, dm_be=1000, dm_wd=0xA5A5A5A5; empty=1 the cycle after.
- SH, addr=0x2002, data=0x1234BEEF → dm_be=1100, dm_wd=0xBEEFBEEF; SW to 0x2004 follows with no bubble and dm_be=1111.
- dm_ack held 0, three SW pushes with DEPTH=2 → st_ready=0 after the second push, third request held; one ack → st_ready=1 next cycle and FIFO order is preserved.
- Entry pending at 0x3000, ld_addr=0x3002 → ld_hit=1; ld_addr=0x3004 → ld_hit=0; after ack → ld_hit=0.
- With DMW_ALIGN_CHK_EN, SW to 0x4001 → no entry, empty stays 1, st_misalign=1 for exactly one cycle. Without the macro → entry with dm_addr=0x4000 and dm_be=1111.
- rst_n=0 for one edge while two entries are pending → dm_we=0, empty=1, st_ready=1 on the next cycle.

Source files
------------

// File: rtl/dmw_store_buf_pkg.sv
// Shared store-buffer types and the store opcodes (formerly instr_def.v defines).
package dmw_store_buf_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wd;
  } sb_entry_t;

endpackage

// File: rtl/dmw_ext.sv
// Store encoder: op + byte offset + rt value -> byte enables, replicated data.
// DMW_ALIGN_CHK_EN enables misalignment detection for SH/SW.
module dmw_ext
  import dmw_store_buf_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic        is_store_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = '0;
    wd_o       = '0;
    is_store_o = 1'b0;
    misalign_o = 1'b0;
    case (op_i)
      OP_SB: begin
        is_store_o = 1'b1;
        be_o       = 4'b0001 << addr_lo_i;
        wd_o       = {4{data_i[7:0]}};
      end
      OP_SH: begin
        is_store_o = 1'b1;
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wd_o       = {2{data_i[15:0]}};
`ifdef DMW_ALIGN_CHK_EN
        misalign_o = addr_lo_i[0];
`endif
      end
      OP_SW: begin
        is_store_o = 1'b1;
        be_o       = 4'b1111;
        wd_o       = data_i;
`ifdef DMW_ALIGN_CHK_EN
        misalign_o = (addr_lo_i != 2'b00);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmw_store_buf.sv
// FIFO store buffer draining to data memory, with pending-store load hit detection.
// DMW_ALIGN_CHK_EN (in dmw_ext) rejects misaligned SH/SW and pulses st_misalign.
module dmw_store_buf
  import dmw_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [5:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_misalign,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wd,
  input  logic        dm_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             misalign_q, misalign_d;
  sb_entry_t        mem_q [DEPTH];

  logic [3:0]  enc_be;
  logic [31:0] enc_wd;
  logic        enc_is_store;
  logic        enc_misalign;
  logic        take, push, pop;
  sb_entry_t   new_entry, head;
  logic        unused_ld_lo;

  dmw_ext u_ext (
    .op_i       (st_op),
    .addr_lo_i  (st_addr[1:0]),
    .data_i     (st_data),
    .be_o       (enc_be),
    .wd_o       (enc_wd),
    .is_store_o (enc_is_store),
    .misalign_o (enc_misalign)
  );

  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign dm_we    = !empty;

  // A rejected misaligned store is still consumed, so it never stalls the pipe.
  assign take = st_valid && st_ready && enc_is_store;
  assign push = take && !enc_misalign;
  assign pop  = dm_we && dm_ack;

  assign new_entry = '{waddr: st_addr[31:2], be: enc_be, wd: enc_wd};
  assign head      = mem_q[rd_ptr_q];

  assign dm_addr = dm_we ? {head.waddr, 2'b00} : '0;
  assign dm_be   = dm_we ? head.be : '0;
  assign dm_wd   = dm_we ? head.wd : '0;

  assign st_misalign  = misalign_q;
  assign unused_ld_lo = ^ld_addr[1:0];

  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].waddr == ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    misalign_d = take && enc_misalign;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by count/valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

endmodule
